// File: rtl/uart_pixel_pkg.sv
// Shared types and helpers for the UART pixel writer.
// Holds the FSM encoding, the default geometry and the RGB888 to RGB444 conversion.
package uart_pixel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } writer_state_t;

    localparam int IMG_WIDTH_DEF  = 160;
    localparam int IMG_HEIGHT_DEF = 120;
    localparam int PIXELS         = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;
    localparam int X_W            = $clog2(IMG_WIDTH_DEF);
    localparam int Y_W            = $clog2(IMG_HEIGHT_DEF);

    // Plain truncation: keep the top nibble of each channel, no rounding.
    function automatic logic [11:0] rgb888_to_444(input logic [23:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

endpackage

// File: rtl/pixel_timeout_counter.sv
// Silence watchdog for a partially received frame.
// clr reloads the count; each enabled cycle counts down; expired flags the final idle cycle.
module pixel_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 10000000,
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Reloading to TIMEOUT_CYCLES-2 makes the abort decision land on the idle cycle
    // that puts the error pulse exactly TIMEOUT_CYCLES clocks after the last strobe.
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/uart_pixel_writer.sv
// Writes received RGB888 pixels as RGB444 into a raster-ordered frame buffer,
// tracking x/y, flagging frame completion and aborting stalled partial frames.
module uart_pixel_writer
    import uart_pixel_pkg::*;
#(
    parameter int IMG_WIDTH      = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT     = IMG_HEIGHT_DEF,
    parameter int ADDR_WIDTH     = 15,
    parameter int TIMEOUT_CYCLES = 10000000,
    localparam int PX_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
    localparam int PY_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [23:0]           pixel_in,
    input  logic                  pixel_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [11:0]           mem_data,
    output logic                  mem_we,
    output logic [PX_W-1:0]       pixel_x,
    output logic [PY_W-1:0]       pixel_y,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err,
    output logic [7:0]            frame_count
);

    // pixel_valid is a one-cycle strobe with no back-pressure: every strobe is
    // accepted and produces exactly one mem_we on the following cycle.
    writer_state_t state_q, state_d;

    logic [PX_W-1:0]       x_q, x_d;
    logic [PY_W-1:0]       y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [11:0]           mem_data_q, mem_data_d;
    logic                  mem_we_q, mem_we_d;
    logic                  frame_done_q, frame_done_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [7:0]            frame_count_q, frame_count_d;

    logic last_pixel;
    logic x_wrap;
    logic to_en;
    logic to_expired;

    assign x_wrap     = (x_q == PX_W'(IMG_WIDTH - 1));
    assign last_pixel = x_wrap && (y_q == PY_W'(IMG_HEIGHT - 1));

    // The watchdog only runs while a frame is open and the line is silent.
    assign to_en = (state_q == RECV) && !pixel_valid;

    pixel_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clr    (!to_en),
        .en     (to_en),
        .expired(to_expired)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        mem_we_d      = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        frame_count_d = frame_count_q;

        // A strobe is accepted in every state, so it also beats a coincident timeout.
        if (pixel_valid) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = rgb888_to_444(pixel_in);
            if (last_pixel) begin
                x_d           = '0;
                y_d           = '0;
                addr_d        = '0;
                state_d       = DONE;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
            end else begin
                state_d = RECV;
                addr_d  = addr_q + 1'b1;
                if (x_wrap) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                RECV: begin
                    if (to_expired) begin
                        state_d       = IDLE;
                        x_d           = '0;
                        y_d           = '0;
                        addr_d        = '0;
                        timeout_err_d = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign busy        = (state_q == RECV);
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/uart_pixel_writer.md
Name: uart_pixel_writer

Overview:
- Sits directly downstream of the UART pixel receiver. Consumes its 24-bit RGB888 pixel and one-cycle "pixel complete" strobe.
- Converts each pixel to RGB444 and generates raster-ordered write address and write enable for a single-port frame-buffer BRAM.
- Tracks x/y position, signals frame completion, and aborts a stalled partial frame after a silence timeout.

Parameters:
IMG_WIDTH, 160, pixels per line
IMG_HEIGHT, 120, lines per frame
ADDR_WIDTH, 15, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
TIMEOUT_CYCLES, 10000000, idle clocks inside a frame before abort (100 ms at 100 MHz)

Ports:
clock  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
pixel_in  in  24  RGB888 pixel {R[23:16],G[15:8],B[7:0]}, valid only with pixel_valid
pixel_valid  in  1  one-cycle strobe, one pixel per strobe; minimum spacing 1 cycle
mem_addr  out  ADDR_WIDTH  frame-buffer write address (linear, y*IMG_WIDTH+x)
mem_data  out  12  RGB444 {R[7:4],G[7:4],B[7:4]}
mem_we  out  1  write enable, one cycle per accepted pixel
pixel_x  out  clog2(IMG_WIDTH)  column of the next pixel to be written
pixel_y  out  clog2(IMG_HEIGHT)  row of the next pixel to be written
busy  out  1  high while a frame is partially received (state RECV)
frame_done  out  1  one-cycle pulse, same cycle as mem_we of the last pixel
timeout_err  out  1  one-cycle pulse on partial-frame abort
frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset, asynchronous: all outputs 0; state IDLE; counters and timeout counter 0.
- Latency: pixel_valid in cycle n -> mem_we=1 with registered mem_addr/mem_data in cycle n+1.
  - mem_addr/mem_data hold their last value when mem_we=0.
- Colour conversion is pure truncation, with no rounding: mem_data = {pixel_in[23:20], pixel_in[15:12], pixel_in[7:4]}.
- Address is a separate linear counter incremented per pixel. It is not computed with a multiplier.
- FSM states: IDLE, RECV, DONE.
  - IDLE: pixel_valid -> write at the current address (0), advance counters, go to RECV.
    - If IMG_WIDTH*IMG_HEIGHT == 1, go directly to DONE.
  - RECV, pixel_valid:
    - Write, then advance x.
    - x == IMG_WIDTH-1: x <- 0, y <- y+1.
    - Last pixel (x == IMG_WIDTH-1 and y == IMG_HEIGHT-1): write it, then x, y, addr <- 0; go to DONE.
  - RECV, no pixel_valid: timeout counter increments.
    - On reaching TIMEOUT_CYCLES-1: timeout_err pulse next cycle; x, y, addr <- 0; go to IDLE; frame_count unchanged.
  - Any pixel_valid clears the timeout counter.
  - DONE: lasts exactly one cycle.
    - frame_done=1 is aligned with the final mem_we.
    - frame_count increments.
    - Return to IDLE.
    - pixel_valid during DONE is accepted as pixel (0,0) of the next frame, and the state goes to RECV.
- pixel_valid coincident with timeout expiry: the pixel wins. It is written, the counter clears, and no abort occurs.
- busy = (state == RECV).
- pixel_x/pixel_y always equal the coordinates the next accepted pixel will be written to.
- Reset mid-frame: immediate return to IDLE/address 0. A pending mem_we is dropped, and no frame_done or timeout_err is produced.

Decomposition:
- Package uart_pixel_pkg:
  - writer_state_t enum {IDLE, RECV, DONE}.
  - Function rgb888_to_444.
  - Localparams PIXELS = IMG_WIDTH*IMG_HEIGHT, X_W, Y_W.
- One sub-module, pixel_timeout_counter: a loadable down-counter with clear, enable and expired pulse, parameterised by TIMEOUT_CYCLES.
- Raster counters and FSM stay in the top.

Test Plan (bench overrides: IMG_WIDTH=4, IMG_HEIGHT=3, ADDR_WIDTH=4, TIMEOUT_CYCLES=20):
1. Reset, then pixel_valid with pixel_in=24'hFF8010 -> next cycle mem_we=1, mem_addr=0, mem_data=12'hF81, busy=1, pixel_x=1, pixel_y=0.
2. 12 pixels spaced 3 cycles apart -> mem_addr sequence 0..11; pixel_y increments after addr 3 and after addr 7; frame_done pulses with addr 11; frame_count=1; busy=0 afterwards.
3. 12 pixels back-to-back, then a 13th pixel in the DONE cycle -> 13th written at addr 0; state RECV; pixel_x=1; frame_count=1.
4. 5 pixels, then silence -> timeout_err pulses 20 cycles after the last strobe; pixel_x=pixel_y=0; frame_count unchanged; next pixel written to addr 0.
5. Pixel arriving exactly at timeout-expiry cycle -> written at addr 5; no timeout_err.
6. Assert reset after 7 pixels, including in the cycle before mem_we -> all outputs 0 immediately; no frame_done. Then 256 full frames -> frame_count wraps to 0.
